mem_sp_arbiter: RTL and testbench

- Shares one single-port sky130 SRAM macro (the 32x128 1RW type: active-low csb/web, inputs registered on posedge, array write/read on negedge) between NUM_REQ requesters.
- Round-robin arbitration, one access per cycle, valid/ready request handshake, registered read response tagged per requester.
- Optional post-reset zero-fill sequencer so downstream logic never reads X.
- Sits between the compute-side memory clients and the mem_sp_sky130 macro wrapper.

---
 rtl/mem_sp_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_sp_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_sp_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM macro between NUM_REQ requesters,
// with an optional post-reset zero-fill pass and a one-cycle tagged read response.
module mem_sp_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_BIT  = 32,
  parameter int DEPTH     = 128,
  parameter int ADDR_BIT  = $clog2(DEPTH),
  parameter int INIT_ZERO = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_wen,
  input  logic [NUM_REQ*ADDR_BIT-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_BIT-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_BIT-1:0]          rsp_rdata,
  output logic                         init_done,
  output logic                         mem_csb,
  output logic                         mem_web,
  output logic [ADDR_BIT-1:0]          mem_addr,
  output logic [DATA_BIT-1:0]          mem_din,
  input  logic [DATA_BIT-1:0]          mem_dout
);

  localparam int PTR_BIT = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RESET = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
  localparam logic       DONE_RESET = (INIT_ZERO != 0) ? 1'b0 : 1'b1;

  localparam logic [ADDR_BIT-1:0] LAST_ADDR  = ADDR_BIT'(DEPTH - 1);
  localparam logic [ADDR_BIT:0]   DEPTH_W    = (ADDR_BIT + 1)'(DEPTH);
  localparam logic [PTR_BIT-1:0]  LAST_PTR   = PTR_BIT'(NUM_REQ - 1);
  localparam logic                POW2_DEPTH = (DEPTH == (1 << ADDR_BIT)) ? 1'b1 : 1'b0;

  function automatic logic [NUM_REQ-1:0] onehot_f(input logic [PTR_BIT-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = {NUM_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PTR_BIT-1:0] next_ptr_f(input logic [PTR_BIT-1:0] idx);
    return (idx == LAST_PTR) ? {PTR_BIT{1'b0}} : idx + PTR_BIT'(1);
  endfunction

  logic [0:0]          state_r;
  logic [ADDR_BIT-1:0] init_cnt_r;
  logic                init_done_r;
  logic [PTR_BIT-1:0]  rr_r;
  logic [NUM_REQ-1:0]  rd_pend_r;
  logic                rd_oor_r;
  logic [NUM_REQ-1:0]  rsp_valid_r;
  logic [DATA_BIT-1:0] rsp_rdata_r;

  logic                found_s;
  logic [PTR_BIT-1:0]  grant_idx_s;
  logic [PTR_BIT-1:0]  cand_idx_s;
  logic                xfer_s;
  logic                g_wen_s;
  logic [ADDR_BIT-1:0] g_addr_s;
  logic [DATA_BIT-1:0] g_wdata_s;
  logic                in_range_s;

  // round-robin search starting at the pointer, wrapping at NUM_REQ
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = {PTR_BIT{1'b0}};
    cand_idx_s  = {PTR_BIT{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx_s = PTR_BIT'((int'(rr_r) + k) % NUM_REQ);
      if (!found_s && req_valid[cand_idx_s]) begin
        found_s     = 1'b1;
        grant_idx_s = cand_idx_s;
      end else begin
        found_s     = found_s;
      end
    end
  end

  assign xfer_s     = !rst && (state_r == ST_RUN) && found_s;
  assign g_wen_s    = req_wen[grant_idx_s];
  assign g_addr_s   = req_addr[grant_idx_s*ADDR_BIT +: ADDR_BIT];
  assign g_wdata_s  = req_wdata[grant_idx_s*DATA_BIT +: DATA_BIT];
  // out-of-range addresses only exist when DEPTH is not a power of two
  assign in_range_s = POW2_DEPTH || ({1'b0, g_addr_s} < DEPTH_W);
  assign req_ready  = xfer_s ? onehot_f(grant_idx_s) : {NUM_REQ{1'b0}};

  // macro drive: zero-fill sweep, granted access, or idle with chip deselected
  always_comb begin
    mem_csb  = 1'b1;
    mem_web  = 1'b1;
    mem_addr = {ADDR_BIT{1'b0}};
    mem_din  = {DATA_BIT{1'b0}};
    if (rst) begin
      mem_csb = 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          mem_csb  = 1'b0;
          mem_web  = 1'b0;
          mem_addr = init_cnt_r;
        end
        ST_RUN: begin
          if (xfer_s && in_range_s) begin
            mem_csb  = 1'b0;
            mem_web  = !g_wen_s;
            mem_addr = g_addr_s;
            mem_din  = g_wdata_s;
          end else begin
            mem_csb  = 1'b1;
          end
        end
        default: begin
          mem_csb = 1'b1;
        end
      endcase
    end
  end

  // state, zero-fill counter and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RESET;
      init_cnt_r  <= {ADDR_BIT{1'b0}};
      init_done_r <= DONE_RESET;
      rr_r        <= {PTR_BIT{1'b0}};
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= init_cnt_r + ADDR_BIT'(1);
          if (init_cnt_r == LAST_ADDR) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (xfer_s) begin
            rr_r <= next_ptr_f(grant_idx_s);
          end
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

  // read response: tag the reader at accept, capture macro output one edge later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_r   <= {NUM_REQ{1'b0}};
      rd_oor_r    <= 1'b0;
      rsp_valid_r <= {NUM_REQ{1'b0}};
      rsp_rdata_r <= {DATA_BIT{1'b0}};
    end else begin
      rd_pend_r   <= (xfer_s && !g_wen_s) ? onehot_f(grant_idx_s) : {NUM_REQ{1'b0}};
      rd_oor_r    <= !in_range_s;
      rsp_valid_r <= rd_pend_r;
      if (rd_pend_r != {NUM_REQ{1'b0}}) begin
        rsp_rdata_r <= rd_oor_r ? {DATA_BIT{1'b0}} : mem_dout;
      end
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign init_done = init_done_r;

endmodule

// File: tb/tb_mem_sp_arbiter.sv
// Directed bench for mem_sp_arbiter with a behavioural 1RW macro model and a
// queue-based scoreboard checked by an independent response monitor.
module tb_mem_sp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_wen;
  logic [13:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        init_done;
  logic        mem_csb;
  logic        mem_web;
  logic [6:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  mem_sp_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 1RW macro model: inputs registered on posedge, array access on negedge
  logic [31:0] sram [0:127];
  logic        csb_q, web_q;
  logic [6:0]  addr_q;
  logic [31:0] din_q;
  always @(posedge clk) begin
    csb_q  <= mem_csb;
    web_q  <= mem_web;
    addr_q <= mem_addr;
    din_q  <= mem_din;
  end
  always @(negedge clk) begin
    if (csb_q == 1'b0) begin
      if (web_q == 1'b0) sram[addr_q] <= din_q;
      else mem_dout <= sram[addr_q];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: every presented response must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(e.vld));
          chk("rsp_rdata", rsp_rdata, e.data);
          chk("rsp_latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  // one cycle of stimulus; checks grant and macro drive, queues expected read data
  task automatic step(input string nm, input logic [1:0] v, input logic [1:0] w,
                      input logic [6:0] a0, input logic [6:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] exp_rdy, input logic [31:0] exp_d);
    logic [8:0] exp_mem;
    exp_t e;
    req_valid = v;
    req_wen   = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    if (exp_rdy == 2'b01)      exp_mem = {1'b0, !w[0], a0};
    else if (exp_rdy == 2'b10) exp_mem = {1'b0, !w[1], a1};
    else                       exp_mem = {1'b1, 1'b1, 7'd0};
    @(negedge clk);
    chk({nm, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({nm, "_mem"}, 32'({mem_csb, mem_web, mem_addr}), 32'(exp_mem));
    if (exp_rdy != 2'b00 && (w & exp_rdy) == 2'b00) begin
      e.vld  = exp_rdy;
      e.data = exp_d;
      e.due  = cyc + 2;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    step(nm, 2'b00, 2'b00, 7'd0, 7'd0, 32'h0, 32'h0, 2'b00, 32'h0);
  endtask

  task automatic run_init(input int n, input logic [1:0] v);
    req_valid = v;
    req_wen   = 2'b00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("init_drive", 32'({mem_csb, mem_web, mem_addr, init_done, req_ready}),
          32'({1'b0, 1'b0, 7'(i), 1'b0, 2'b00}));
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_state"}, 32'({init_done, req_ready, rsp_valid, mem_csb}), 32'({1'b0, 2'b00, 2'b00, 1'b1}));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; req_wen = 2'b00; req_addr = 14'd0; req_wdata = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    chk("reset_rdata", rsp_rdata, 32'h0);

    // zero-fill after reset release
    @(posedge clk); #1;
    rst = 1'b0;
    run_init(128, 2'b00);
    chk("init_done_rise", 32'(init_done), 32'h1);
    idle("post_init_idle");
    step("rd_zero", 2'b01, 2'b00, 7'd5, 7'd0, 32'h0, 32'h0, 2'b01, 32'h0);

    // write then immediate read-back
    step("wr3", 2'b01, 2'b01, 7'd3, 7'd0, 32'hDEADBEEF, 32'h0, 2'b01, 32'h0);
    step("rd3", 2'b01, 2'b00, 7'd3, 7'd0, 32'h0, 32'h0, 2'b01, 32'hDEADBEEF);

    // preload 10/20, leave pointer at 0, then full contention alternates
    step("wr10", 2'b01, 2'b01, 7'd10, 7'd0, 32'hA0A0A0A0, 32'h0, 2'b01, 32'h0);
    step("wr20", 2'b10, 2'b10, 7'd0, 7'd20, 32'h0, 32'hB0B0B0B0, 2'b10, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step("rr_alt", 2'b11, 2'b00, 7'd10, 7'd20, 32'h0, 32'h0, 2'b01, 32'hA0A0A0A0);
      else            step("rr_alt", 2'b11, 2'b00, 7'd10, 7'd20, 32'h0, 32'h0, 2'b10, 32'hB0B0B0B0);
    end

    // read/write contention on addr 7: read granted first sees the old value
    step("cont_a", 2'b11, 2'b10, 7'd7, 7'd7, 32'h0, 32'h12345678, 2'b01, 32'h0);
    step("cont_b", 2'b10, 2'b10, 7'd7, 7'd7, 32'h0, 32'h12345678, 2'b10, 32'h0);
    step("cont_c", 2'b01, 2'b00, 7'd7, 7'd7, 32'h0, 32'h0, 2'b01, 32'h12345678);
    // pointer now at 1: the write wins and the later read sees it
    step("cont_d", 2'b11, 2'b10, 7'd7, 7'd7, 32'h0, 32'hCAFEF00D, 2'b10, 32'h0);
    step("cont_e", 2'b01, 2'b00, 7'd7, 7'd7, 32'h0, 32'h0, 2'b01, 32'hCAFEF00D);

    // idle gap: pointer unchanged, response data held afterwards
    step("gap_rd", 2'b01, 2'b00, 7'd3, 7'd0, 32'h0, 32'h0, 2'b01, 32'hDEADBEEF);
    idle("gap_idle1");
    idle("gap_idle2");
    @(negedge clk);
    chk("hold_valid", 32'(rsp_valid), 32'h0);
    chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    step("gap_ptr", 2'b11, 2'b00, 7'd10, 7'd20, 32'h0, 32'h0, 2'b10, 32'hB0B0B0B0);
    idle("drain1");
    idle("drain2");

    // reset with a read in flight: response must be lost
    req_valid = 2'b01; req_wen = 2'b00; req_addr = {7'd0, 7'd3};
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b00;
    #1;
    chk_reset("rst_run");
    @(posedge clk); #1;
    rst = 1'b0;
    run_init(50, 2'b11);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk_reset("rst_init");
    rst = 1'b0;
    run_init(128, 2'b11);
    chk("reinit_done", 32'(init_done), 32'h1);
    step("rd_refill", 2'b01, 2'b00, 7'd3, 7'd0, 32'h0, 32'h0, 2'b01, 32'h0);
    idle("end1");
    idle("end2");
    idle("end3");
    chk("sb_empty", 32'(sbq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
